// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One single-bit full-adder cell is reused across a WIDTH-bit addition,
// processing one bit pair per clock, LSB first. The carry is fed back
// through a register. The result is assembled in a shift register and
// published on Sum/Carry together with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_out_q, carry_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               s_bit;
  logic               c_bit;
  logic               acc_clr_s;
  logic               acc_en_s;
  logic [WIDTH-1:0]   sum_final_s;

  // The single full-adder cell: the only adder logic in the design.
  assign s_bit = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign c_bit = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);

  // Result accumulator. Only the lower WIDTH-1 sum bits ever need storing:
  // the MSB sum bit comes straight from the cell on the final RUN edge.
  generate
    if (WIDTH == 1) begin : g_acc_none
      assign sum_final_s = s_bit;
    end else begin : g_acc
      logic [WIDTH-2:0] acc_q, acc_d;

      // Accumulator next state: clear on accept, shift in s_bit while running.
      always_comb begin
        acc_d = acc_q;
        if (acc_clr_s) begin
          acc_d = {(WIDTH-1){1'b0}};
        end else if (acc_en_s) begin
          if (WIDTH == 2) begin
            acc_d = s_bit;
          end else begin
            acc_d = {s_bit, acc_q[WIDTH-2:1]};
          end
        end else begin
          acc_d = acc_q;
        end
      end

      // Accumulator register with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= {(WIDTH-1){1'b0}};
        end else begin
          acc_q <= acc_d;
        end
      end

      assign sum_final_s = {s_bit, acc_q};
    end
  endgenerate

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    acc_clr_s   = 1'b0;
    acc_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d    = A;
          op_b_d    = B;
          carry_d   = Cin;
          cnt_d     = {CNT_W{1'b0}};
          acc_clr_s = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        op_a_d   = op_a_q >> 1;
        op_b_d   = op_b_q >> 1;
        carry_d  = c_bit;
        cnt_d    = cnt_q + CNT_W'(1);
        acc_en_s = 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d       = sum_final_s;
          carry_out_d = c_bit;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= {WIDTH{1'b0}};
      op_b_q      <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] A8 = 8'h00;
  logic [7:0] B8 = 8'h00;
  logic       Cin8 = 1'b0;
  logic       busy8, done8, Carry8;
  logic [7:0] Sum8;

  logic       start1 = 1'b0;
  logic [0:0] A1 = 1'b0;
  logic [0:0] B1 = 1'b0;
  logic       Cin1 = 1'b0;
  logic       busy1, done1, Carry1;
  logic [0:0] Sum1;

  int tests = 0;
  int fails = 0;

  logic [7:0] held_sum = 8'h00;
  logic       held_carry = 1'b0;
  logic [7:0] a_hist [0:31];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .Cin(Cin8),
    .busy(busy8), .done(done8), .Sum(Sum8), .Carry(Carry8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
    .busy(busy1), .done(done1), .Sum(Sum1), .Carry(Carry1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=8 operation with cycle-accurate busy/done/hold checks.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] exp_sum, input logic exp_carry);
    A8 = a; B8 = b; Cin8 = cin; start8 = 1'b1;
    tick();                          // accepting edge 0
    start8 = 1'b0;
    A8 = ~a; B8 = ~b; Cin8 = ~cin;   // must not affect the result
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, 32'(busy8), 32'd1);
      chk({tag, "_nodone"}, 32'(done8), 32'd0);
      chk({tag, "_sumhold"}, 32'(Sum8), 32'(held_sum));
      chk({tag, "_carryhold"}, 32'(Carry8), 32'(held_carry));
      tick();
    end
    // now just after edge 8: DONE cycle
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy8), 32'd0);
    chk({tag, "_sum"}, 32'(Sum8), 32'(exp_sum));
    chk({tag, "_carry"}, 32'(Carry8), 32'(exp_carry));
    held_sum = exp_sum;
    held_carry = exp_carry;
    tick();
    chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_sum_after"}, 32'(Sum8), 32'(exp_sum));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'(Sum8), 32'd0);
    chk("rst_carry8", 32'(Carry8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_sum1", 32'(Sum1), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: basic addition
    run8("t1", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);

    // Test 2: wrap-around cases, Sum/Carry hold between them
    run8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    chk("t2_hold_sum", 32'(Sum8), 32'h00);
    chk("t2_hold_carry", 32'(Carry8), 32'd1);
    run8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run8("t2c", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    // Test 3: start held high, A changes every cycle
    for (int k = 0; k < 32; k++) a_hist[k] = 8'h10 + 8'(k * 7);
    B8 = 8'h22; Cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      A8 = a_hist[k];
      tick();                        // now just after edge k
      chk("t3_busy", 32'(busy8), ((k <= 7) || (k >= 10 && k <= 17)) ? 32'd1 : 32'd0);
      chk("t3_done", 32'(done8), ((k == 8) || (k == 18)) ? 32'd1 : 32'd0);
      if (k == 8) begin
        chk("t3_sum1", 32'(Sum8), 32'h32);
        chk("t3_carry1", 32'(Carry8), 32'd0);
      end
      if (k == 18) begin
        chk("t3_sum2", 32'(Sum8), 32'h78);
        chk("t3_carry2", 32'(Carry8), 32'd0);
      end
    end
    start8 = 1'b0;
    held_sum = 8'h78;
    held_carry = 1'b0;
    tick();
    chk("t3_idle", 32'(busy8), 32'd0);

    // Test 4: reset in the middle of RUN
    A8 = 8'h55; B8 = 8'hAA; Cin8 = 1'b0; start8 = 1'b1;
    tick();                          // edge 0
    start8 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t4_busy", 32'(busy8), 32'd1);
    end
    rst = 1'b1;
    tick();                          // edge 4 with rst
    chk("t4_busy_rst", 32'(busy8), 32'd0);
    chk("t4_done_rst", 32'(done8), 32'd0);
    chk("t4_sum_rst", 32'(Sum8), 32'h00);
    chk("t4_carry_rst", 32'(Carry8), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_no_done", 32'(done8), 32'd0);
      chk("t4_no_busy", 32'(busy8), 32'd0);
    end
    held_sum = 8'h00;
    held_carry = 1'b0;
    run8("t4b", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Test 5: rst and start on the same edge
    rst = 1'b1; start8 = 1'b1; A8 = 8'hFF; B8 = 8'hFF; Cin8 = 1'b1;
    tick();
    chk("t5_busy", 32'(busy8), 32'd0);
    chk("t5_done", 32'(done8), 32'd0);
    chk("t5_sum", 32'(Sum8), 32'h00);
    chk("t5_carry", 32'(Carry8), 32'd0);
    rst = 1'b0; start8 = 1'b0;
    tick();
    chk("t5_still_idle", 32'(busy8), 32'd0);
    chk("t5_still_sum", 32'(Sum8), 32'h00);

    // Test 6: WIDTH=1 instance
    A1 = 1'b1; B1 = 1'b1; Cin1 = 1'b1; start1 = 1'b1;
    tick();                          // accepting edge
    start1 = 1'b0; A1 = 1'b0; B1 = 1'b0; Cin1 = 1'b0;
    chk("t6_busy", 32'(busy1), 32'd1);
    chk("t6_nodone", 32'(done1), 32'd0);
    chk("t6_sumhold", 32'(Sum1), 32'd0);
    tick();
    chk("t6_done", 32'(done1), 32'd1);
    chk("t6_busy_off", 32'(busy1), 32'd0);
    chk("t6_sum", 32'(Sum1), 32'd1);
    chk("t6_carry", 32'(Carry1), 32'd1);
    tick();
    chk("t6_done_pulse", 32'(done1), 32'd0);
    chk("t6_sum_hold", 32'(Sum1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that time-multiplexes one single-bit full-adder cell across a WIDTH-bit addition. On a start request it latches the operands and feeds the cell one bit pair per clock, LSB first, with a registered carry loop. It assembles the result and signals completion with a one-cycle done pulse. It sits where a ripple-carry adder would otherwise go, and trades latency for area.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request to begin an addition; sampled only in IDLE
A  input  WIDTH  operand A; sampled on the accepting edge only
B  input  WIDTH  operand B; sampled on the accepting edge only
Cin  input  1  carry-in; sampled on the accepting edge only
busy  output  1  high while bits are being processed (RUN state)
done  output  1  one-cycle pulse; Sum and Carry are valid from this cycle
Sum  output  WIDTH  registered result; holds until the next result is written
Carry  output  1  registered carry-out; holds with Sum

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset: state=IDLE. busy=0, done=0, Sum=0, Carry=0. Internal shift registers, carry flop and bit counter are cleared. rst has priority over every other input on the same edge.
- Datapath: exactly one one-bit full-adder cell. Its inputs are opA[0], opB[0] and carry_q. Its outputs are s_bit and c_bit. No other adder logic is permitted.
- Counter width: max(1, clog2(WIDTH)).
- States:
  - IDLE: busy=0, done=0. If start=1 at an edge: opA<=A, opB<=B, carry_q<=Cin, cnt<=0, acc<=0, go to RUN.
  - RUN: busy=1. Each edge: opA/opB shift right by 1 (zero fill); acc shifts right with s_bit entering the MSB; carry_q<=c_bit; cnt<=cnt+1. On the edge where cnt==WIDTH-1: Sum<={s_bit, acc[WIDTH-1:1]} (for WIDTH=1, Sum<=s_bit); Carry<=c_bit; go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. Next edge goes to IDLE unconditionally.
- Latency: with start accepted at edge 0, the RUN edges are 1..WIDTH. done is high in the cycle following edge WIDTH, so done is observed at edge WIDTH+1. The next start can be accepted at edge WIDTH+2 or later.
- start while in RUN or DONE is ignored; it is not queued.
- A, B and Cin changes after the accepting edge do not affect the result in progress.
- Sum and Carry change only on the final RUN edge or on reset. They hold their previous values throughout IDLE and RUN.
- Reset mid-operation: the operation is abandoned, no done pulse is produced, and outputs return to 0. The next start after reset is processed normally.
- Arithmetic: {Carry, Sum} = A + B + Cin, modulo 2^(WIDTH+1). Both wrap-around cases (all-ones plus one, all-ones plus all-ones plus one) follow from this.

Test Plan:
1. WIDTH=8. A=0x3C, B=0x5A, Cin=0, start pulsed at edge 0 -> busy high for edges 1..8; done high only in the cycle after edge 8; Sum=0x96, Carry=0.
2. WIDTH=8. A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Carry=1. Then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Carry=1. Sum/Carry hold their values between the two operations.
3. WIDTH=8. start=1 held continuously with A changing every cycle -> the first operands are used and the result is correct. Restarts occur only from IDLE, so done pulses are spaced 10 cycles apart.
4. WIDTH=8. A=0x55, B=0xAA; assert rst at edge 4 of RUN -> the next cycle shows busy=0, done=0, Sum=0x00, Carry=0 and no done pulse. A new start with A=0x01, B=0x01 -> Sum=0x02.
5. rst=1 and start=1 on the same edge -> controller stays in IDLE with all outputs 0.
6. WIDTH=1. A=1, B=1, Cin=1 -> busy for one cycle, then done; Sum=1, Carry=1.
